parity_engine: RTL and testbench
================================

# parity_engine

Parametrised, streaming parity generator/checker for the serial datapaths, the next generation of the single-byte parity calculator. It accepts multi-lane words on a valid/ready input and computes one parity bit per lane under a runtime-selectable mode (none/even/odd/mark/space). In check mode it compares the computed parity against received parity bits and keeps error statistics. It sits between the frame assembler/deserialiser and the serialiser/receive FIFO, with one registered output stage.

## Interface
- DATA_W, 8, bits per lane
- LANES, 1, number of independent lanes per word
- CNT_W, 8, width of the saturating error counter
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- ParityMode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5–7 behave as none
- CheckEn  in  1  1 = check InParity, 0 = generate only
- InData  in  LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- InParity  in  LANES  received parity per lane; used only when CheckEn=1
- InValid  in  1  input word valid
- InReady  out  1  engine can accept a word
- OutData  out  LANES*DATA_W  registered copy of the accepted data
- OutParity  out  LANES  computed parity per lane
- OutErr  out  LANES  per-lane mismatch flag for the word in OutData
- OutValid  out  1  output word valid
- OutReady  in  1  downstream accepts the output word
- ClrErr  in  1  clear ErrCount and ErrSticky
- ErrCount  out  CNT_W  words with at least one lane error, saturating
- ErrSticky  out  1  set on any lane error, held until ClrErr or RST

## Operation
- Accept: a word is taken when InValid && InReady. InReady = !OutValid || OutReady; InReady is forced to 0 while RST=1.
- Output register states: EMPTY (OutValid=0) and FULL (OutValid=1).
  - EMPTY + accept → FULL.
  - FULL + OutReady + accept → FULL with the new word.
  - FULL + OutReady + no accept → EMPTY.
  - FULL + !OutReady → hold; OutData, OutParity and OutErr stay stable.
- ParityMode and CheckEn are sampled at the accept cycle only. Changing them mid-stream affects only later words.
- Per-lane parity p[i]:
  - even: XOR-reduce of the lane
  - odd: XNOR-reduce of the lane
  - mark: 1
  - space: 0
  - none: 0
- OutErr[i] = CheckEn && mode≠none && (p[i] ≠ InParity[i]). Mark and space are checked against the constant bit.
- Statistics update in the accept cycle and are visible on the next edge, together with OutErr.
  - If any OutErr bit would be set: ErrCount += 1, saturating at 2^CNT_W−1 (no wrap), and ErrSticky ← 1.
  - ClrErr in the same cycle as an erroring accept: the clear is applied first, giving ErrCount=1 and ErrSticky=1.
  - ClrErr with no error: ErrCount=0, ErrSticky=0.

## Timing
- Latency: 1 cycle from accept to OutValid.
- Throughput: 1 word/cycle while OutReady=1.
- Reset values: OutValid=0, OutData=0, OutParity=0, OutErr=0, ErrCount=0, ErrSticky=0, InReady=0 during RST.
- RST mid-operation discards the held word, with no output handshake. InReady returns to 1 in the first cycle after RST deasserts.
- InReady depends combinationally on OutValid/OutReady. There is no combinational path from InValid to OutValid.
- LANES=1, DATA_W=8, mode even/odd, CheckEn=0 is bit-equivalent to the legacy calculator, delayed by the registered stage.

## Structure
- Package parity_pkg holds the ParityMode encodings (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE) and a helper function mapping undefined codes to PAR_NONE.
- Sub-module parity_lane is combinational: it takes one lane, the mode, CheckEn and the received bit, and returns p and err. It is instantiated LANES times in a generate loop.
- The top level holds the output register, the handshake, and the counter/sticky logic.

## Test plan
- Reset and generate: LANES=1, even, InData=0x07 → OutParity=1 one cycle after accept. Odd, 0x07 → 0. Reset values are checked beforehand.
- Multi-lane check: LANES=4, even, CheckEn=1, InData=0x01FF0300, InParity=4'b0000 → OutErr=4'b1000, ErrCount=1, ErrSticky=1.
- Mark/space/none: mark with InParity=0 → err=1. Space with InParity=0 → err=0. Mode 6 → OutParity=0 and OutErr=0 regardless of data.
- Backpressure: hold OutReady=0 for 5 cycles with InValid=1 → InReady=0, output stable, no word lost or duplicated. Random valid/ready over 1000 words matches the scoreboard.
- Saturation and clear: CNT_W=2, 5 erroring words → ErrCount=3. ClrErr together with an erroring accept → ErrCount=1. ClrErr alone → 0, ErrSticky=0.
- Reset and mode change: RST while FULL → OutValid=0 next cycle and InReady=1 after release. Switching the mode between back-to-back words changes only the second word's parity.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared encodings for the streaming parity engine: parity modes, output stage states,
// and the mapping of raw mode codes onto defined modes.
package parity_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Codes 5..7 are reserved and fall back to no parity
  function automatic par_mode_t to_mode(input logic [MODE_W-1:0] code);
    case (code)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/parity_engine_if.sv
// Word stream in and out of the parity engine; the engine sits on the slave side.
interface parity_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 1
);
  logic [LANES*DATA_W-1:0] InData;
  logic [LANES-1:0]        InParity;
  logic                    InValid;
  logic                    InReady;
  logic [LANES*DATA_W-1:0] OutData;
  logic [LANES-1:0]        OutParity;
  logic [LANES-1:0]        OutErr;
  logic                    OutValid;
  logic                    OutReady;

  modport master (
    output InData, InParity, InValid, OutReady,
    input  InReady, OutData, OutParity, OutErr, OutValid
  );

  modport slave (
    input  InData, InParity, InValid, OutReady,
    output InReady, OutData, OutParity, OutErr, OutValid
  );
endinterface

// File: rtl/parity_lane.sv
// Combinational parity for one lane: computes the parity bit for the selected mode
// and flags a mismatch against the received bit when checking is enabled.
module parity_lane
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  par_mode_t         mode,
  input  logic              check_en,
  input  logic              rx,
  output logic              p,
  output logic              err
);

  always_comb begin
    p   = 1'b0;
    err = 1'b0;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    err = check_en && (mode != PAR_NONE) && (p != rx);
  end

endmodule

// File: rtl/parity_engine.sv
// Streaming multi-lane parity generator/checker with one registered output stage
// and saturating error statistics.
module parity_engine
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [MODE_W-1:0]  ParityMode,
  input  logic               CheckEn,
  input  logic               ClrErr,
  output logic [CNT_W-1:0]   ErrCount,
  output logic               ErrSticky,
  parity_engine_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  out_state_t       state;
  out_state_t       state_nxt;
  logic             in_ready_c;
  logic             accept_c;
  par_mode_t        mode_c;
  logic [LANES-1:0] par_c;
  logic [LANES-1:0] err_c;
  logic [CNT_W-1:0] cnt_base_c;

  assign mode_c   = to_mode(ParityMode);
  assign accept_c = bus.InValid && in_ready_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    parity_lane #(.DATA_W(DATA_W)) u_lane (
      .data     (bus.InData[i*DATA_W +: DATA_W]),
      .mode     (mode_c),
      .check_en (CheckEn),
      .rx       (bus.InParity[i]),
      .p        (par_c[i]),
      .err      (err_c[i])
    );
  end

  // Output stage occupancy
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept_c) state_nxt = ST_FULL;
      ST_FULL:  if (bus.OutReady && !accept_c) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Ready may be taken while the held word leaves in the same cycle
  always_comb begin
    in_ready_c = 1'b0;
    if (!RST && (state == ST_EMPTY || bus.OutReady)) in_ready_c = 1'b1;
  end

  assign bus.InReady  = in_ready_c;
  assign bus.OutValid = (state == ST_FULL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.OutData   <= '0;
      bus.OutParity <= '0;
      bus.OutErr    <= '0;
    end else if (accept_c) begin
      bus.OutData   <= bus.InData;
      bus.OutParity <= par_c;
      bus.OutErr    <= err_c;
    end
  end

  // A clear coinciding with an erroring word counts that word from zero
  assign cnt_base_c = ClrErr ? '0 : ErrCount;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ErrCount  <= '0;
      ErrSticky <= 1'b0;
    end else if (accept_c && (|err_c)) begin
      ErrCount  <= (cnt_base_c == CNT_MAX) ? CNT_MAX : cnt_base_c + CNT_W'(1);
      ErrSticky <= 1'b1;
    end else if (ClrErr) begin
      ErrCount  <= '0;
      ErrSticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_engine.sv
// Self-checking bench for parity_engine (4 lanes, 2-bit counter) against a
// queue-based reference model derived from the parity rules.
module tb_parity_engine;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CNT_MAX = 3;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  par;
    logic [3:0]  err;
  } word_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic [2:0]       ParityMode;
  logic             CheckEn;
  logic             ClrErr;
  logic [CNT_W-1:0] ErrCount;
  logic             ErrSticky;

  parity_engine_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  parity_engine #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ParityMode (ParityMode),
    .CheckEn    (CheckEn),
    .ClrErr     (ClrErr),
    .ErrCount   (ErrCount),
    .ErrSticky  (ErrSticky),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  int    n_vec = 0;
  int    n_err = 0;
  word_t exp_q[$];
  int    m_cnt = 0;
  logic  m_sticky = 1'b0;
  logic  m_after_rst = 1'b1;
  int    n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity from bit counts per lane
  task automatic ref_word(input logic [2:0] mode, input logic ce, input logic [31:0] d,
                          input logic [3:0] rx, output word_t w);
    int ones;
    logic pb;
    w.data = d;
    w.par  = '0;
    w.err  = '0;
    for (int l = 0; l < 4; l++) begin
      ones = 0;
      for (int b = 0; b < 8; b++) ones += int'((d >> (l*8 + b)) & 32'd1);
      case (mode)
        3'd1:    pb = ((ones % 2) == 1);
        3'd2:    pb = ((ones % 2) == 0);
        3'd3:    pb = 1'b1;
        default: pb = 1'b0;
      endcase
      w.par[l] = pb;
      w.err[l] = ce && (mode >= 3'd1 && mode <= 3'd4) && (pb != rx[l]);
    end
  endtask

  // One clock: drive inputs, check ready, update model, check outputs at next negedge
  task automatic step(input logic rst, input logic valid, input logic oready,
                      input logic [2:0] mode, input logic ce, input logic [31:0] d,
                      input logic [3:0] rx, input logic clr);
    logic  exp_ready;
    logic  acc;
    word_t w;
    RST          = rst;
    bus.InValid  = valid;
    bus.OutReady = oready;
    ParityMode   = mode;
    CheckEn      = ce;
    bus.InData   = d;
    bus.InParity = rx;
    ClrErr       = clr;
    #1;
    exp_ready = !rst && (exp_q.size() == 0 || oready);
    chk("in_ready", 32'(bus.InReady), 32'(exp_ready));
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_sticky = 1'b0;
      m_after_rst = 1'b1;
    end else begin
      acc = valid && exp_ready;
      if (exp_q.size() > 0 && oready) void'(exp_q.pop_front());
      if (acc) begin
        ref_word(mode, ce, d, rx, w);
        exp_q.push_back(w);
        n_acc++;
        m_after_rst = 1'b0;
      end
      if (acc && (w.err != 4'd0)) begin
        if (clr) m_cnt = 0;
        m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        m_sticky = 1'b1;
      end else if (clr) begin
        m_cnt = 0;
        m_sticky = 1'b0;
      end
    end
    @(negedge CLK);
    chk("out_valid", 32'(bus.OutValid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_data", bus.OutData, exp_q[0].data);
      chk("out_parity", 32'(bus.OutParity), 32'(exp_q[0].par));
      chk("out_err", 32'(bus.OutErr), 32'(exp_q[0].err));
    end else if (m_after_rst) begin
      chk("rst_data", bus.OutData, 32'd0);
      chk("rst_parity", 32'(bus.OutParity), 32'd0);
      chk("rst_err", 32'(bus.OutErr), 32'd0);
    end
    chk("err_count", 32'(ErrCount), 32'(m_cnt));
    chk("err_sticky", 32'(ErrSticky), 32'(m_sticky));
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] d;
    // Reset state
    step(1, 0, 1, 3'd0, 0, 32'h0, 4'h0, 0);
    step(1, 1, 1, 3'd1, 0, 32'h0, 4'h0, 0);
    step(0, 0, 1, 3'd0, 0, 32'h0, 4'h0, 0);

    // Generate: even then odd on 0x07, back-to-back with a mode switch
    step(0, 1, 1, 3'd1, 0, 32'h07, 4'h0, 0);
    chk("gen_even", 32'(bus.OutParity[0]), 32'd1);
    step(0, 1, 1, 3'd2, 0, 32'h07, 4'h0, 0);
    chk("gen_odd", 32'(bus.OutParity[0]), 32'd0);
    step(0, 0, 1, 3'd0, 0, 32'h0, 4'h0, 0);

    // Multi-lane check
    step(0, 1, 1, 3'd1, 1, 32'h01FF0300, 4'b0000, 0);
    chk("ml_err", 32'(bus.OutErr), 32'b1000);
    chk("ml_cnt", 32'(ErrCount), 32'd1);
    chk("ml_sticky", 32'(ErrSticky), 32'd1);

    // Mark / space / reserved mode
    step(0, 1, 1, 3'd3, 1, 32'h12345678, 4'b0000, 1);
    chk("mark_err", 32'(bus.OutErr), 32'hF);
    step(0, 1, 1, 3'd4, 1, 32'h12345678, 4'b0000, 1);
    chk("space_err", 32'(bus.OutErr), 32'h0);
    step(0, 1, 1, 3'd6, 1, 32'hDEADBEEF, 4'b1111, 0);
    chk("m6_par", 32'(bus.OutParity), 32'h0);
    chk("m6_err", 32'(bus.OutErr), 32'h0);

    // Saturation and clear
    step(0, 0, 1, 3'd0, 0, 32'h0, 4'h0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 3'd3, 1, $urandom, 4'h0, 0);
    chk("sat_cnt", 32'(ErrCount), 32'd3);
    step(0, 1, 1, 3'd3, 1, 32'h0, 4'h0, 1);
    chk("clr_err_cnt", 32'(ErrCount), 32'd1);
    step(0, 0, 1, 3'd0, 0, 32'h0, 4'h0, 1);
    chk("clr_cnt", 32'(ErrCount), 32'd0);
    chk("clr_sticky", 32'(ErrSticky), 32'd0);

    // Backpressure: stall 5 cycles with a word waiting
    step(0, 1, 0, 3'd1, 0, 32'hA5A5_0F0F, 4'h0, 0);
    held = bus.OutData;
    for (int k = 0; k < 5; k++) step(0, 1, 0, 3'd2, 0, $urandom, 4'h0, 0);
    chk("bp_hold", bus.OutData, held);
    step(0, 1, 1, 3'd2, 0, 32'h0000_0001, 4'h0, 0);
    step(0, 0, 1, 3'd0, 0, 32'h0, 4'h0, 0);

    // Reset while full
    step(0, 1, 0, 3'd1, 1, 32'hFFFF_FFFF, 4'hF, 0);
    step(1, 1, 0, 3'd1, 0, 32'h0, 4'h0, 0);
    chk("rst_full_valid", 32'(bus.OutValid), 32'd0);
    step(0, 0, 0, 3'd0, 0, 32'h0, 4'h0, 0);

    // Random traffic
    n_acc = 0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      d = $urandom;
      step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), d,
           4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));
    end
    chk("rand_words", 32'(n_acc), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
